// File: rtl/core_data_req_buffer.sv
// Request FIFO plus credit counter decoupling one core data port from the cluster interconnect.
// Responses pass straight through; credits bound accepted-but-unanswered requests.
package pulp_cluster_package;
  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [31:0] data;
    logic [3:0]  be;
  } core_data_req_t;

  typedef struct packed {
    logic        gnt;
    logic [31:0] r_data;
    logic        r_valid;
  } core_data_rsp_t;
endpackage

module core_data_req_buffer
  import pulp_cluster_package::*;
#(
  parameter int unsigned FIFO_DEPTH      = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  core_data_req_t                         core_req_i,
  output core_data_rsp_t                         core_rsp_o,
  output core_data_req_t                         ic_req_o,
  input  core_data_rsp_t                         ic_rsp_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   busy_o
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  entry_t          mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   occ;
  logic [OW-1:0]   out_cnt;
  logic            full, empty, pop, gnt, push, dec;

  assign full  = (occ == CW'(FIFO_DEPTH));
  assign empty = (occ == '0);
  assign pop   = !empty && ic_rsp_i.gnt;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign gnt   = core_req_i.req && (!full || pop) && (out_cnt < OW'(MAX_OUTSTANDING));
  assign push  = core_req_i.req && gnt;
  // A stray r_valid with no credits must not wrap the counter.
  assign dec   = ic_rsp_i.r_valid && (out_cnt != '0);

  always_comb begin
    core_rsp_o         = '0;
    core_rsp_o.gnt     = gnt;
    core_rsp_o.r_data  = ic_rsp_i.r_data;
    core_rsp_o.r_valid = ic_rsp_i.r_valid;
    ic_req_o           = '0;
    if (!empty) ic_req_o = {1'b1, mem[rd_ptr]};
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{core_req_i.add, core_req_i.wen, core_req_i.data, core_req_i.be};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      out_cnt <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      occ <= occ + 1'b1;
      else if (!push && pop) occ <= occ - 1'b1;
      if (push && !dec)      out_cnt <= out_cnt + 1'b1;
      else if (!push && dec) out_cnt <= out_cnt - 1'b1;
    end
  end

  assign outstanding_o = out_cnt;
  assign busy_o        = (out_cnt != '0);

  a_head_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (ic_req_o.req && !ic_rsp_i.gnt) |=> $stable(ic_req_o));
  a_credit_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_cnt <= OW'(MAX_OUTSTANDING));
  a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(ic_rsp_i.r_valid && out_cnt == '0));
endmodule

// File: tb/tb_core_data_req_buffer.sv
// Bench for core_data_req_buffer: queue-based model compared every cycle, directed
// scenarios with literal expectations, then a randomized run.
module tb_core_data_req_buffer;
  import pulp_cluster_package::*;
  localparam int DEPTH = 2;
  localparam int MAXO  = 4;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b0;
  core_data_req_t core_req = '0;
  core_data_rsp_t core_rsp;
  core_data_req_t ic_req;
  core_data_rsp_t ic_rsp = '0;
  logic [2:0]     outstanding;
  logic           busy;

  int checks = 0;
  int errors = 0;

  core_data_req_t q[$];
  int inflight = 0;

  core_data_req_buffer #(.FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .core_req_i(core_req), .core_rsp_o(core_rsp),
    .ic_req_o(ic_req), .ic_rsp_i(ic_rsp), .outstanding_o(outstanding), .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: FIFO contents as a queue, plus a count of issued-but-unanswered requests.
  task automatic model_cmp_update();
    int   occ  = q.size();
    int   outs = occ + inflight;
    logic pop  = (occ > 0) && ic_rsp.gnt;
    logic g    = core_req.req && ((occ < DEPTH) || pop) && (outs < MAXO);
    core_data_req_t exp_ic = (occ > 0) ? q[0] : '0;
    chk("gnt", 70'(core_rsp.gnt), 70'(g));
    chk("r_valid", 70'(core_rsp.r_valid), 70'(ic_rsp.r_valid));
    chk("r_data", 70'(core_rsp.r_data), 70'(ic_rsp.r_data));
    chk("ic_req", ic_req, exp_ic);
    chk("outstanding", 70'(outstanding), 70'(outs));
    chk("busy", 70'(busy), 70'(outs != 0));
    if (pop) begin
      void'(q.pop_front());
      inflight++;
    end
    if (g) q.push_back(core_req);
    if (ic_rsp.r_valid) inflight--;
  endtask

  task automatic step(input logic c_req, input logic [31:0] add, input logic wen,
                      input logic [31:0] data, input logic [3:0] be,
                      input logic ig, input logic rv, input logic [31:0] rd);
    @(negedge clk);
    core_req = '{c_req, add, wen, data, be};
    ic_rsp   = '{ig, rd, rv};
    #1;
    model_cmp_update();
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && (q.size() > 0 || inflight > 0); i++)
      step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, inflight > 0, $urandom);
    step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    chk("drain_outstanding", 70'(outstanding), 70'd0);
  endtask

  initial begin
    int grants;
    #3;
    chk("reset_ic_req", ic_req, 70'd0);
    chk("reset_outstanding", 70'(outstanding), 70'd0);
    chk("reset_busy", 70'(busy), 70'd0);
    chk("reset_core_rsp", 70'(core_rsp), 70'd0);
    #10;
    @(negedge clk);
    rst_ni = 1'b1;

    // Single read
    step(1'b1, 32'h1000_0010, 1'b1, 32'h0, 4'hf, 1'b0, 1'b0, 32'h0);
    chk("t1_c0_gnt", 70'(core_rsp.gnt), 70'd1);
    chk("t1_c0_icreq", 70'(ic_req.req), 70'd0);
    chk("t1_c0_busy", 70'(busy), 70'd0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    chk("t1_c1_icreq", 70'(ic_req.req), 70'd1);
    chk("t1_c1_add", 70'(ic_req.add), 70'h1000_0010);
    chk("t1_c1_wen", 70'(ic_req.wen), 70'd1);
    chk("t1_c1_busy", 70'(busy), 70'd1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("t1_c2_icreq", 70'(ic_req.req), 70'd0);
    chk("t1_c2_rvalid", 70'(core_rsp.r_valid), 70'd1);
    chk("t1_c2_rdata", 70'(core_rsp.r_data), 70'hDEAD_BEEF);
    chk("t1_c2_busy", 70'(busy), 70'd1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    chk("t1_c3_busy", 70'(busy), 70'd0);

    // Backpressure: interconnect never grants
    grants = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h2000 + 32'(4 * i), 1'b0, 32'hA000 + 32'(i), 4'hf, 1'b0, 1'b0, 32'h0);
      grants += int'(core_rsp.gnt);
      if (i > 0) chk("t2_head_add", 70'(ic_req.add), 70'h2000);
    end
    chk("t2_grants", 70'(grants), 70'd2);
    chk("t2_last_gnt", 70'(core_rsp.gnt), 70'd0);
    drain();

    // Credit limit: immediate grants, no responses
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'h3000 + 32'(4 * i), 1'b1, 32'h0, 4'hf, 1'b1, 1'b0, 32'h0);
      grants += int'(core_rsp.gnt);
    end
    chk("t3_grants", 70'(grants), 70'd4);
    chk("t3_outstanding", 70'(outstanding), 70'd4);
    chk("t3_gnt_blocked", 70'(core_rsp.gnt), 70'd0);
    step(1'b1, 32'h3100, 1'b1, 32'h0, 4'hf, 1'b1, 1'b1, 32'h1234_5678);
    chk("t3_gnt_same_cycle", 70'(core_rsp.gnt), 70'd0);
    step(1'b1, 32'h3100, 1'b1, 32'h0, 4'hf, 1'b1, 1'b0, 32'h0);
    chk("t3_gnt_after_rvalid", 70'(core_rsp.gnt), 70'd1);
    drain();

    // Full FIFO with simultaneous push and pop
    step(1'b1, 32'h0, 1'b0, 32'h11, 4'hf, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h4, 1'b0, 32'h22, 4'hf, 1'b0, 1'b0, 32'h0);
    step(1'b1, 32'h8, 1'b0, 32'h33, 4'hf, 1'b1, 1'b0, 32'h0);
    chk("t4_gnt_full_pop", 70'(core_rsp.gnt), 70'd1);
    chk("t4_head0", 70'(ic_req.add), 70'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    chk("t4_head1", 70'(ic_req.add), 70'h4);
    chk("t4_outstanding", 70'(outstanding), 70'd3);
    step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    chk("t4_head2", 70'(ic_req.add), 70'h8);
    drain();

    // Accept and r_valid together at three credits
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h5000 + 32'(4 * i), 1'b1, 32'h0, 4'hf, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h500c, 1'b1, 32'h0, 4'hf, 1'b1, 1'b1, 32'hCAFE_0001);
    chk("t5_outstanding_before", 70'(outstanding), 70'd3);
    chk("t5_gnt", 70'(core_rsp.gnt), 70'd1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
    chk("t5_outstanding_after", 70'(outstanding), 70'd3);
    drain();

    // Reset mid-operation: two queued, one in flight
    step(1'b1, 32'h6000, 1'b1, 32'h0, 4'hf, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h6004, 1'b1, 32'h0, 4'hf, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'h6008, 1'b1, 32'h0, 4'hf, 1'b0, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    chk("t6_outstanding_pre", 70'(outstanding), 70'd3);
    chk("t6_icreq_pre", 70'(ic_req.req), 70'd1);
    #1;
    core_req = '0;
    ic_rsp   = '0;
    rst_ni   = 1'b0;
    #1;
    chk("t6_icreq", 70'(ic_req.req), 70'd0);
    chk("t6_outstanding", 70'(outstanding), 70'd0);
    chk("t6_busy", 70'(busy), 70'd0);
    q.delete();
    inflight = 0;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;

    // Randomized traffic with varying pressure
    for (int i = 0; i < 3000; i++) begin
      int req_pct = (i < 1000) ? 80 : ((i < 2000) ? 40 : 95);
      int gnt_pct = (i < 1000) ? 70 : ((i < 2000) ? 90 : 25);
      step($urandom_range(99) < req_pct, {$urandom_range(32'hFFFF), 2'b00}, 1'($urandom),
           $urandom, 4'($urandom), $urandom_range(99) < gnt_pct,
           (inflight > 0) && ($urandom_range(99) < 50), $urandom);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
